// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the data-memory stage: state encoding, the bubble
// instruction word and register index width.
package cpu_pkg;

   localparam int REG_IDX_W = 5;
   localparam logic [31:0] NOP_INSTR = 32'b0;

   typedef enum logic {
      IDLE,
      BUSY
   } dm_state_t;

   // Data memory is word addressed; any non-zero byte offset is rejected.
   function automatic logic wordAligned(input logic [1:0] lowBits);
      return lowBits == 2'b00;
   endfunction

endpackage

// File: rtl/dm_timeout_ctr.sv
// Counts cycles spent waiting for a memory acknowledge and flags the last allowed cycle.
module dm_timeout_ctr #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   // Saturates on the expiry value; the owner clears it when the wait ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expire) begin
         count <= count + 1'b1;
      end
   end

   assign expire = (count == LAST);

endmodule

// File: rtl/dm_mem_access.sv
// Memory-access pipeline stage: issues loads/stores over a req/ack handshake, stalls
// upstream while waiting, and registers the writeback values for the WB stage.
module dm_mem_access
   import cpu_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 DMMemRead,
   input  logic                 DMMemWrite,
   input  logic                 DMMemToReg,
   input  logic                 DMRegWrite,
   input  logic [DATA_W-1:0]    instructionDM,
   input  logic [DATA_W-1:0]    ALUresDM,
   input  logic [DATA_W-1:0]    DMRead2,
   input  logic [REG_IDX_W-1:0] DMwriteReg,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [DATA_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic [DATA_W-1:0]    mem_rdata,
   input  logic                 mem_ack,
   output logic                 stall,
   output logic                 WBRegWrite,
   output logic [REG_IDX_W-1:0] WBwriteReg,
   output logic [DATA_W-1:0]    WBdata,
   output logic [DATA_W-1:0]    instructionWB,
   output logic                 bus_err
);

   localparam logic [DATA_W-1:0] BUBBLE = DATA_W'(NOP_INSTR);

   dm_state_t state, nextState;

   logic access, legal;
   logic startAccess, illegalAccess, ackDone, timedOut;
   logic ctrClear, ctrEnable, ctrExpire;

   logic                 holdMemToReg;
   logic                 holdRegWrite;
   logic [REG_IDX_W-1:0] holdWriteReg;
   logic [DATA_W-1:0]    holdInstr;

   assign access = DMMemRead | DMMemWrite;
   assign legal  = (DMMemRead ^ DMMemWrite) & wordAligned(ALUresDM[1:0]);

   dm_timeout_ctr #(
      .TIMEOUT(TIMEOUT)
   ) uTimeout (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (ctrClear),
      .enable(ctrEnable),
      .expire(ctrExpire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // An acknowledge arriving on the expiry cycle completes the access normally.
   always_comb begin
      nextState     = state;
      startAccess   = 1'b0;
      illegalAccess = 1'b0;
      ackDone       = 1'b0;
      timedOut      = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               if (legal) begin
                  startAccess = 1'b1;
                  nextState   = BUSY;
               end else begin
                  illegalAccess = 1'b1;
               end
            end
         end
         BUSY: begin
            if (mem_ack) begin
               ackDone   = 1'b1;
               nextState = IDLE;
            end else if (ctrExpire) begin
               timedOut  = 1'b1;
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   assign ctrClear  = startAccess | ackDone | timedOut;
   assign ctrEnable = (state == BUSY) & ~mem_ack;

   // Stall is released on the completing cycle so upstream advances on the same edge.
   assign stall = rst_n & (startAccess | ((state == BUSY) & ~mem_ack & ~ctrExpire));

   // Bus-side registers double as the holding copy of address, store data and direction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         holdMemToReg <= 1'b0;
         holdRegWrite <= 1'b0;
         holdWriteReg <= '0;
         holdInstr    <= '0;
         bus_err      <= 1'b0;
      end else begin
         bus_err <= illegalAccess | timedOut;
         if (startAccess) begin
            mem_req      <= 1'b1;
            mem_we       <= DMMemWrite;
            mem_addr     <= ALUresDM;
            mem_wdata    <= DMRead2;
            holdMemToReg <= DMMemToReg;
            holdRegWrite <= DMRegWrite;
            holdWriteReg <= DMwriteReg;
            holdInstr    <= instructionDM;
         end else if (ackDone || timedOut) begin
            mem_req <= 1'b0;
         end
      end
   end

   // Writeback registers: pass-through when idle, bubbles while waiting, result on completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         WBRegWrite    <= 1'b0;
         WBwriteReg    <= '0;
         WBdata        <= '0;
         instructionWB <= '0;
      end else if (startAccess) begin
         WBRegWrite    <= 1'b0;
         instructionWB <= BUBBLE;
      end else if (ackDone) begin
         WBRegWrite    <= holdRegWrite;
         WBwriteReg    <= holdWriteReg;
         WBdata        <= holdMemToReg ? mem_rdata : mem_addr;
         instructionWB <= holdInstr;
      end else if (timedOut) begin
         WBRegWrite    <= 1'b0;
         WBwriteReg    <= holdWriteReg;
         WBdata        <= mem_addr;
         instructionWB <= holdInstr;
      end else if (state == BUSY) begin
         WBRegWrite    <= 1'b0;
         instructionWB <= BUBBLE;
      end else begin
         WBRegWrite    <= DMRegWrite & ~illegalAccess;
         WBwriteReg    <= DMwriteReg;
         WBdata        <= ALUresDM;
         instructionWB <= instructionDM;
      end
   end

endmodule

// File: tb/tb_dm_mem_access.sv
// Directed bench for dm_mem_access: ALU pass-through, load/store handshakes, illegal
// accesses, timeout abort and reset mid-access, with a writeback scoreboard.
module tb_dm_mem_access;

   logic        clk;
   logic        rst_n;
   logic        DMMemRead, DMMemWrite, DMMemToReg, DMRegWrite;
   logic [31:0] instructionDM, ALUresDM, DMRead2;
   logic [4:0]  DMwriteReg;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;
   logic        stall;
   logic        WBRegWrite;
   logic [4:0]  WBwriteReg;
   logic [31:0] WBdata, instructionWB;
   logic        bus_err;

   typedef struct {
      logic        regWrite;
      logic [4:0]  writeReg;
      logic [31:0] data;
      logic        checkData;
      logic [31:0] instr;
      logic        busErr;
   } wbExp_t;

   wbExp_t scoreboard[$];

   int checkCount = 0;
   int passCount  = 0;
   int failCount  = 0;

   dm_mem_access #(
      .DATA_W (32),
      .TIMEOUT(4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .DMMemRead    (DMMemRead),
      .DMMemWrite   (DMMemWrite),
      .DMMemToReg   (DMMemToReg),
      .DMRegWrite   (DMRegWrite),
      .instructionDM(instructionDM),
      .ALUresDM     (ALUresDM),
      .DMRead2      (DMRead2),
      .DMwriteReg   (DMwriteReg),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ack      (mem_ack),
      .stall        (stall),
      .WBRegWrite   (WBRegWrite),
      .WBwriteReg   (WBwriteReg),
      .WBdata       (WBdata),
      .instructionWB(instructionWB),
      .bus_err      (bus_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount = checkCount + 1;
      assert (observed === expected) passCount = passCount + 1;
      else begin
         failCount = failCount + 1;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic m2r, input logic rw,
                                input logic [31:0] instr, input logic [31:0] alu,
                                input logic [31:0] rd2, input logic [4:0] wreg);
      DMMemRead     = rd;
      DMMemWrite    = wr;
      DMMemToReg    = m2r;
      DMRegWrite    = rw;
      instructionDM = instr;
      ALUresDM      = alu;
      DMRead2       = rd2;
      DMwriteReg    = wreg;
   endtask

   task automatic pushExpected(input logic rw, input logic [4:0] wreg, input logic [31:0] data,
                               input logic checkData, input logic [31:0] instr, input logic busErr);
      wbExp_t e;
      e.regWrite  = rw;
      e.writeReg  = wreg;
      e.data      = data;
      e.checkData = checkData;
      e.instr     = instr;
      e.busErr    = busErr;
      scoreboard.push_back(e);
   endtask

   task automatic checkOutput(input string tag);
      wbExp_t e;
      if (scoreboard.size() == 0) begin
         checkCount = checkCount + 1;
         failCount  = failCount + 1;
         $error("[TB] FAIL %s: scoreboard empty, observed WBdata 0x%0h expected a queued entry", tag, WBdata);
      end else begin
         e = scoreboard.pop_front();
         check({tag, ".WBRegWrite"}, 32'(WBRegWrite), 32'(e.regWrite));
         check({tag, ".WBwriteReg"}, 32'(WBwriteReg), 32'(e.writeReg));
         if (e.checkData) check({tag, ".WBdata"}, WBdata, e.data);
         check({tag, ".instructionWB"}, instructionWB, e.instr);
         check({tag, ".bus_err"}, 32'(bus_err), 32'(e.busErr));
      end
   endtask

   // Drives one legal load/store from a negedge, acking after ackDelay waiting cycles.
   task automatic runAccess(input string tag, input logic isWrite, input logic m2r, input logic rw,
                            input logic [31:0] instr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [4:0] wreg,
                            input int ackDelay, input logic [31:0] rdata, output int stallHigh);
      applyStimulus(~isWrite, isWrite, m2r, rw, instr, addr, wdata, wreg);
      pushExpected(rw, wreg, m2r ? rdata : addr, 1'b1, instr, 1'b0);
      #1;
      check({tag, ".stallIdle"}, 32'(stall), 32'd1);
      stallHigh = int'(stall);
      for (int i = 0; i < ackDelay; i++) begin
         @(negedge clk);
         check({tag, ".mem_req"}, 32'(mem_req), 32'd1);
         check({tag, ".mem_addr"}, mem_addr, addr);
         check({tag, ".mem_we"}, 32'(mem_we), 32'(isWrite));
         if (isWrite) check({tag, ".mem_wdata"}, mem_wdata, wdata);
         check({tag, ".bubbleRegWrite"}, 32'(WBRegWrite), 32'd0);
         check({tag, ".bubbleInstr"}, instructionWB, 32'd0);
         #1;
         stallHigh = stallHigh + int'(stall);
      end
      @(negedge clk);
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      check({tag, ".ackReq"}, 32'(mem_req), 32'd1);
      check({tag, ".ackAddr"}, mem_addr, addr);
      check({tag, ".ackWe"}, 32'(mem_we), 32'(isWrite));
      if (isWrite) check({tag, ".ackWdata"}, mem_wdata, wdata);
      #1;
      check({tag, ".stallAck"}, 32'(stall), 32'd0);
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      checkOutput(tag);
      check({tag, ".reqDropped"}, 32'(mem_req), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
   endtask

   initial begin
      int stallHigh;
      int busy;
      logic dropped;

      rst_n     = 1'b0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
      #12;
      check("reset.mem_req", 32'(mem_req), 32'd0);
      check("reset.mem_addr", mem_addr, 32'd0);
      check("reset.stall", 32'(stall), 32'd0);
      check("reset.WBRegWrite", 32'(WBRegWrite), 32'd0);
      check("reset.WBdata", WBdata, 32'd0);
      check("reset.instructionWB", instructionWB, 32'd0);
      check("reset.bus_err", 32'(bus_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] ALU pass-through");
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h00A12820, 32'h1234, 32'h0, 5'd5);
      pushExpected(1'b1, 5'd5, 32'h1234, 1'b1, 32'h00A12820, 1'b0);
      #1 check("alu.stall", 32'(stall), 32'd0);
      @(negedge clk);
      checkOutput("alu");
      check("alu.stallAfter", 32'(stall), 32'd0);
      check("alu.noReq", 32'(mem_req), 32'd0);

      $display("[TB] load with late ack");
      runAccess("load", 1'b0, 1'b1, 1'b1, 32'h8C080040, 32'h40, 32'h0, 5'd8, 3, 32'hDEADBEEF, stallHigh);
      check("load.stallCycles", 32'(stallHigh), 32'd4);

      $display("[TB] store with immediate ack");
      runAccess("store", 1'b1, 1'b0, 1'b0, 32'hAC0A0080, 32'h80, 32'hA5A5A5A5, 5'd10, 0, 32'h0, stallHigh);
      check("store.occupancy", 32'(stallHigh + 1), 32'd2);

      $display("[TB] misaligned load");
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h8C030042, 32'h42, 32'h0, 5'd3);
      pushExpected(1'b0, 5'd3, 32'h42, 1'b1, 32'h8C030042, 1'b1);
      #1 check("misalign.stall", 32'(stall), 32'd0);
      @(negedge clk);
      checkOutput("misalign");
      check("misalign.noReq", 32'(mem_req), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
      @(negedge clk);
      check("misalign.pulseEnd", 32'(bus_err), 32'd0);

      $display("[TB] read and write together");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'hFC000050, 32'h50, 32'h11, 5'd7);
      pushExpected(1'b0, 5'd7, 32'h50, 1'b1, 32'hFC000050, 1'b1);
      #1 check("both.stall", 32'(stall), 32'd0);
      @(negedge clk);
      checkOutput("both");
      check("both.noReq", 32'(mem_req), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);

      $display("[TB] load timeout");
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h8C090100, 32'h100, 32'h0, 5'd9);
      pushExpected(1'b0, 5'd9, 32'h0, 1'b0, 32'h8C090100, 1'b1);
      #1 check("timeout.stallIdle", 32'(stall), 32'd1);
      busy    = 0;
      dropped = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!mem_req) begin
            dropped = 1'b1;
            break;
         end
         busy = busy + 1;
         #1 check("timeout.stallBusy", 32'(stall), 32'(busy < 4));
      end
      check("timeout.dropped", 32'(dropped), 32'd1);
      check("timeout.busyCycles", 32'(busy), 32'd4);
      checkOutput("timeout");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
      @(negedge clk);
      check("timeout.pulseEnd", 32'(bus_err), 32'd0);
      check("timeout.idleStall", 32'(stall), 32'd0);

      $display("[TB] reset during access");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h8C0B0200, 32'h200, 32'h0, 5'd11);
      @(negedge clk);
      check("rstBusy.mem_req", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rstBusy.reqDropped", 32'(mem_req), 32'd0);
      check("rstBusy.stall", 32'(stall), 32'd0);
      check("rstBusy.WBRegWrite", 32'(WBRegWrite), 32'd0);
      check("rstBusy.WBwriteReg", 32'(WBwriteReg), 32'd0);
      check("rstBusy.WBdata", WBdata, 32'd0);
      check("rstBusy.instructionWB", instructionWB, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rstBusy.stillIdle", 32'(mem_req), 32'd0);
      runAccess("postReset", 1'b0, 1'b1, 1'b1, 32'h8C0C0044, 32'h44, 32'h0, 5'd12, 1, 32'h12345678, stallHigh);
      check("postReset.stallCycles", 32'(stallHigh), 32'd2);

      @(negedge clk);
      check("scoreboard.drained", 32'(scoreboard.size()), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
